// File: rtl/frame_ctrl.sv
// Collects SAMPLE_SIZE signed samples into a frame, then pulses load_en and start on the next two cycles and waits in BUSY for done.
// in_ready is low from LOAD until BUSY exits. The optional BUSY watchdog is enabled by the macro FRAME_CTRL_TIMEOUT_EN.
module frame_ctrl #(
    parameter int SAMPLE_SIZE    = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          flush,
    input  logic                          done,
    output logic [SAMPLE_SIZE*DATA_W-1:0] frame_data,
    output logic                          load_en,
    output logic                          start,
    output logic                          busy,
    output logic [4:0]                    fill_level,
    output logic [15:0]                   frame_cnt,
    output logic                          timeout_err
);

    if (SAMPLE_SIZE < 2 || SAMPLE_SIZE > 16) begin : g_bad_sample_size
        $error("frame_ctrl: SAMPLE_SIZE must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("frame_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_LOAD,
        S_START,
        S_BUSY
    } state_t;

    state_t                          r_state;
    logic [4:0]                      r_fill;
    logic [15:0]                     r_frame_cnt;
    logic [SAMPLE_SIZE*DATA_W-1:0]   r_frame;
    logic                            r_load_en;
    logic                            r_start;
    logic                            r_busy;
    logic                            w_accept;
    logic                            w_last;

    assign in_ready = (r_state == S_IDLE) || (r_state == S_FILL);
    // flush wins over an accept in the same cycle
    assign w_accept = in_valid && in_ready && !flush;
    assign w_last   = (r_fill == 5'(SAMPLE_SIZE - 1));

`ifdef FRAME_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] r_wdog;
    logic          r_timeout_err;
    logic          w_wdog_exp;
    assign w_wdog_exp  = (r_wdog == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_fill      <= 5'd0;
            r_frame_cnt <= 16'd0;
            r_load_en   <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
`ifdef FRAME_CTRL_TIMEOUT_EN
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_load_en <= 1'b0;
            r_start   <= 1'b0;
            if (flush) begin
                r_state <= S_IDLE;
                r_fill  <= 5'd0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_FILL: begin
                        if (w_accept) begin
                            r_fill <= r_fill + 5'd1;
                            if (w_last) begin
                                r_state   <= S_LOAD;
                                r_load_en <= 1'b1;
                            end else begin
                                r_state <= S_FILL;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_state <= S_START;
                        r_start <= 1'b1;
                    end
                    S_START: begin
                        r_state <= S_BUSY;
                        r_busy  <= 1'b1;
`ifdef FRAME_CTRL_TIMEOUT_EN
                        r_wdog  <= '0;
`endif
                    end
                    S_BUSY: begin
                        if (done) begin
                            r_state     <= S_IDLE;
                            r_fill      <= 5'd0;
                            r_busy      <= 1'b0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
`ifdef FRAME_CTRL_TIMEOUT_EN
                        end else if (w_wdog_exp) begin
                            r_state       <= S_IDLE;
                            r_fill        <= 5'd0;
                            r_busy        <= 1'b0;
                            r_timeout_err <= 1'b1;
                        end else begin
                            r_wdog <= r_wdog + 1'b1;
`endif
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_fill  <= 5'd0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Slots not written in this frame keep their previous contents
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < SAMPLE_SIZE; k++) begin
                if (r_fill == 5'(k)) begin
                    r_frame[k*DATA_W +: DATA_W] <= in_data;
                end
            end
        end
    end

    assign frame_data = r_frame;
    assign load_en    = r_load_en;
    assign start      = r_start;
    assign busy       = r_busy;
    assign fill_level = r_fill;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_frame_ctrl.sv
// Randomised and directed bench for frame_ctrl with a frame scoreboard and a cycle-level reference model.
module tb_frame_ctrl;
    localparam int SS  = 8;
    localparam int DW  = 8;
    localparam int TMO = 16;
`ifdef FRAME_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    in_data  = '0;
    logic             flush    = 1'b0;
    logic             done     = 1'b0;
    logic             in_ready;
    logic [SS*DW-1:0] frame_data;
    logic             load_en;
    logic             start;
    logic             busy;
    logic [4:0]       fill_level;
    logic [15:0]      frame_cnt;
    logic             timeout_err;

    frame_ctrl #(.SAMPLE_SIZE(SS), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .done(done), .frame_data(frame_data),
        .load_en(load_en), .start(start), .busy(busy), .fill_level(fill_level),
        .frame_cnt(frame_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [SS*DW-1:0] frame;
        logic [15:0]      cnt;
    } exp_t;
    exp_t sb[$];

    // Reference model: m_age < 0 while collecting, otherwise edges since the frame filled
    int            m_fill;
    int            m_age;
    int            m_cnt;
    bit            m_terr;
    logic [DW-1:0] m_buf[SS];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [SS*DW-1:0] m_frame();
        logic [SS*DW-1:0] f;
        for (int k = 0; k < SS; k++) f[k*DW +: DW] = m_buf[k];
        return f;
    endfunction

    function automatic logic [25:0] m_vec();
        return {m_age < 0, m_age == 1, m_age == 2, m_age >= 3, 5'(m_fill), 16'(m_cnt), m_terr};
    endfunction

    function automatic logic [25:0] dut_vec();
        return {in_ready, load_en, start, busy, fill_level, frame_cnt, timeout_err};
    endfunction

    task automatic model_reset();
        m_fill = 0; m_age = -1; m_cnt = 0; m_terr = 1'b0;
        for (int k = 0; k < SS; k++) m_buf[k] = '0;
        sb.delete();
    endtask

    // Drive one cycle of inputs, check the pre-edge state, then advance the model past the edge
    task automatic step(input bit v, input logic [DW-1:0] d, input bit fl, input bit dn);
        exp_t e;
        in_valid = v; in_data = d; flush = fl; done = dn;
        @(negedge clk);
        chk("cycle", dut_vec(), m_vec());
        chk("frame_data", frame_data, m_frame());
        if (fl) begin
            m_fill = 0; m_age = -1;
        end else if (m_age < 0) begin
            if (v) begin
                m_buf[m_fill] = d;
                m_fill++;
                if (m_fill == SS) begin
                    m_age = 1;
                    e.frame = m_frame();
                    e.cnt   = 16'(m_cnt);
                    sb.push_back(e);
                end
            end
        end else if (m_age >= 3 && dn) begin
            m_fill = 0; m_age = -1; m_cnt = (m_cnt + 1) % 65536;
        end else if (m_age >= 3 && TMO_EN && (m_age - 2) == TMO) begin
            m_fill = 0; m_age = -1; m_terr = 1'b1;
        end else if (m_age >= 1) begin
            m_age++;
        end
        @(posedge clk); #1;
    endtask

    task automatic fill_frame(input logic [DW-1:0] base);
        for (int k = 0; k < SS; k++) step(1'b1, base + DW'(k), 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: every load_en must match the next completed frame
    logic prev_load = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (start) chk("start_after_load", prev_load, 1);
            if (load_en) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_load_en: got load_en=1 expected no pending frame at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("sb_frame", frame_data, e.frame);
                    chk("sb_cnt", frame_cnt, e.cnt);
                end
            end
        end
        prev_load = load_en;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within budget");
        $fatal(1);
    end

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #2;
        chk("reset_vec", dut_vec(), m_vec());
        chk("reset_frame", frame_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // basic frame with in_valid held through LOAD/START/BUSY
        fill_frame(8'h01);
        for (int k = 0; k < 4; k++) step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("basic_frame", frame_data, 64'h0807060504030201);
        chk("basic_busy", busy, 1);
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        chk("done_cnt", frame_cnt, 1);
        chk("done_ready", in_ready, 1);

        // flush after five samples, then a full frame
        for (int k = 0; k < 5; k++) step(1'b1, 8'h10 + 8'(k), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("flush_fill", fill_level, 0);
        idle(2);
        fill_frame(8'h20);
        idle(3);
        step(1'b0, '0, 1'b0, 1'b1);

        // done and flush together in BUSY
        fill_frame(8'h30);
        idle(3);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("df_cnt", frame_cnt, 2);
        chk("df_busy", busy, 0);

        // watchdog: no done after entering BUSY
        fill_frame(8'h40);
        idle(2 + TMO);
`ifdef FRAME_CTRL_TIMEOUT_EN
        chk("tmo_err", timeout_err, 1);
        chk("tmo_idle", in_ready, 1);
        chk("tmo_cnt", frame_cnt, 2);
`else
        chk("tmo_still_busy", busy, 1);
        chk("tmo_err_zero", timeout_err, 0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("tmo_done_cnt", frame_cnt, 3);
`endif

        // asynchronous reset in FILL with three samples held
        for (int k = 0; k < 3; k++) step(1'b1, 8'h70 + 8'(k), 1'b0, 1'b0);
        chk("pre_reset_fill", fill_level, 3);
        rst = 1'b0;
        #1;
        chk("rst_async_vec", dut_vec(), {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0});
        chk("rst_async_frame", frame_data, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;

        // randomised traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 70, DW'($urandom), $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 12);
        end
        for (int i = 0; i < 40; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_ctrl.md
FRAME_CTRL -- requirements
Module: frame_ctrl

Interface
REQ-001: Parameter SAMPLE_SIZE, default 8, SHALL set the number of samples per frame (range 2..16).
REQ-002: Parameter DATA_W, default 8, SHALL set the signed sample width in bits.
REQ-003: Parameter TIMEOUT_CYCLES, default 1024, SHALL set the BUSY watchdog limit in clk cycles.
REQ-004: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005: rst  input  1  SHALL be an asynchronous, active-low reset (low = reset).
REQ-006: in_valid  input  1  SHALL indicate in_data holds a sample.
REQ-007: in_data  input  DATA_W  SHALL carry a signed sample.
REQ-008: in_ready  output  1  SHALL indicate the block accepts a sample this cycle.
REQ-009: flush  input  1  SHALL be a synchronous abort of the current frame.
REQ-010: done  input  1  SHALL be a single-cycle pulse from downstream processing marking frame completion.
REQ-011: frame_data  output  SAMPLE_SIZE*DATA_W  SHALL carry the frame buffer; sample k at bits [k*DATA_W +: DATA_W].
REQ-012: load_en  output  1  SHALL be the one-cycle enable to the sample register bank.
REQ-013: start  output  1  SHALL be the one-cycle start pulse to downstream processing.
REQ-014: busy  output  1  SHALL be high while waiting for done.
REQ-015: fill_level  output  5  SHALL report the number of samples held in the current frame.
REQ-016: frame_cnt  output  16  SHALL count completed frames.
REQ-017: timeout_err  output  1  SHALL be a sticky watchdog error flag.

Function
REQ-018: FSM states SHALL be IDLE, FILL, LOAD, START and BUSY.
REQ-019: in_ready SHALL be 1 in IDLE and FILL and 0 in all other states.
REQ-020: A sample SHALL be accepted when in_valid and in_ready are both 1; it is written to buffer slot fill_level, and fill_level increments.
REQ-021: IDLE SHALL go to FILL on the first accept; if SAMPLE_SIZE samples are then held, the next state SHALL be LOAD.
REQ-022: An accept that brings fill_level to SAMPLE_SIZE SHALL go to LOAD on the next edge; no further accepts occur until return to IDLE.
REQ-023: LOAD SHALL assert load_en for exactly one cycle, with frame_data stable, then go to START.
REQ-024: START SHALL assert start for exactly one cycle, then go to BUSY; busy SHALL be 1 only in BUSY.
REQ-025: BUSY on done SHALL go to IDLE, clear fill_level to 0 and increment frame_cnt, which wraps 0xFFFF to 0x0000.
REQ-026: done outside BUSY SHALL be ignored.
REQ-027: frame_data SHALL hold its contents outside accepts; slots not yet written in a frame keep their previous-frame values.
REQ-028: flush SHALL take priority over all other events in any state: next state IDLE, fill_level 0, no accept that cycle, frame_cnt unchanged, and no load_en or start in the following cycle.
REQ-029: done and flush in the same BUSY cycle SHALL act as flush, so frame_cnt does not increment.

Reset
REQ-030: While rst is low, the block SHALL go to IDLE with fill_level, frame_cnt, frame_data, load_en, start, busy and timeout_err all 0, and in_ready 1.
REQ-031: Reset asserted mid-frame or in BUSY SHALL discard the frame without any load_en or start pulse.

Configuration
REQ-032: With macro FRAME_CTRL_TIMEOUT_EN defined, the block SHALL count cycles in BUSY (counter cleared on entry). If TIMEOUT_CYCLES cycles pass without done, it SHALL set timeout_err, go to IDLE and clear fill_level, without incrementing frame_cnt.
REQ-033: With FRAME_CTRL_TIMEOUT_EN defined, timeout_err SHALL clear only on reset.
REQ-034: Without FRAME_CTRL_TIMEOUT_EN, the counter SHALL be absent, timeout_err tied to 0, and BUSY left only by done, flush or reset.

Verification
REQ-035: The bench SHALL cover basic frame, SAMPLE_SIZE=8: stream 1..8 back-to-back -> load_en one cycle after 8th accept, start next cycle, frame_data = 0x0807060504030201, busy=1.
REQ-036: The bench SHALL cover backpressure: in_valid held during LOAD/START/BUSY -> in_ready=0 and no sample accepted; done -> frame_cnt=1, in_ready=1 next cycle.
REQ-037: The bench SHALL cover flush: flush after 5 samples -> fill_level=0, IDLE, no load_en; the next 8 samples form a complete frame.
REQ-038: The bench SHALL cover done and flush in the same cycle in BUSY -> IDLE, frame_cnt unchanged.
REQ-039: The bench SHALL cover timeout with the macro defined and TIMEOUT_CYCLES=16: no done -> timeout_err=1 after 16 BUSY cycles, IDLE, frame_cnt unchanged; without the macro -> remains BUSY.
REQ-040: The bench SHALL cover reset: rst low in FILL with fill_level=3 -> all outputs at reset values, in_ready=1 asynchronously.
